// File: rtl/ad_ip_jesd204_tpl_adc_pn_stats_if.sv
// up_* register bus between the ADC TPL host side and
// the PN statistics slave.
interface ad_ip_jesd204_tpl_adc_pn_stats_if;
  logic        up_wreq;
  logic [9:0]  up_waddr;
  logic [31:0] up_wdata;
  logic        up_wack;
  logic        up_rreq;
  logic [9:0]  up_raddr;
  logic [31:0] up_rdata;
  logic        up_rack;

  modport master (
    output up_wreq, up_waddr, up_wdata,
    output up_rreq, up_raddr,
    input  up_wack, up_rdata, up_rack
  );

  modport slave (
    input  up_wreq, up_waddr, up_wdata,
    input  up_rreq, up_raddr,
    output up_wack, up_rdata, up_rack
  );
endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_pn_stats.sv
// Per-channel PN error counters, sticky flags and
// maskable interrupt on the up_* register bus.
module ad_ip_jesd204_tpl_adc_pn_stats #(
  parameter int         NUM_CHANNELS  = 1,
  parameter int         COUNTER_WIDTH = 16,
  parameter logic [9:0] BASE_ADDR     = 10'h200
) (
  input  logic                    clk,
  input  logic                    reset,
  ad_ip_jesd204_tpl_adc_pn_stats_if.slave up,
  input  logic [NUM_CHANNELS-1:0] pn_err,
  input  logic [NUM_CHANNELS-1:0] pn_oos,
  input  logic [NUM_CHANNELS-1:0] enable,
  output logic                    irq
);

  localparam int NC = NUM_CHANNELS;
  localparam int CW = COUNTER_WIDTH;

  typedef logic [CW-1:0] cnt_t;

  logic          wreq_q, wreq_d;
  logic [5:0]    woff_q, woff_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rack_q, rack_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          count_en_q, count_en_d;
  logic [NC-1:0] err_q, err_d;
  logic [NC-1:0] oos_q, oos_d;
  logic [NC-1:0] mask_q, mask_d;
  logic          irq_q, irq_d;
  cnt_t          live_q [NC];
  cnt_t          live_d [NC];
  cnt_t          snap_q [NC];
  cnt_t          snap_d [NC];

  logic          whit, rhit;
  logic [5:0]    roff;
  logic [31:0]   rd_val;
  logic          wr_ctl, snap_stb, clr_stb;
  logic [NC-1:0] w1c_err, w1c_oos;
  logic [NC-1:0] act_err, act_oos;
  logic          inc;
  cnt_t          base;
  logic          unused_wdata;

  assign whit = up.up_wreq &&
    (up.up_waddr[9:6] == BASE_ADDR[9:6]);
  assign rhit = up.up_rreq &&
    (up.up_raddr[9:6] == BASE_ADDR[9:6]);
  assign roff = up.up_raddr[5:0];

  assign act_err = pn_err & enable;
  assign act_oos = pn_oos & enable;

  assign unused_wdata = ^wdata_q;

  always_comb begin
    rd_val = '0;
    unique case (roff)
      6'h00: rd_val = {8'h01, 8'(CW), 8'h00, 8'(NC)};
      6'h01: rd_val = {31'd0, count_en_q};
      6'h02: rd_val = 32'(err_q);
      6'h03: rd_val = 32'(oos_q);
      6'h04: rd_val = 32'(mask_q);
      6'h05: rd_val = 32'(act_oos);
      default: begin
        for (int i = 0; i < NC; i++) begin
          if (roff == 6'(16 + i)) rd_val = 32'(snap_q[i]);
        end
      end
    endcase
  end

  always_comb begin
    wreq_d  = whit;
    woff_d  = up.up_waddr[5:0];
    wdata_d = up.up_wdata;
    rack_d  = rhit;
    rdata_d = rhit ? rd_val : '0;
  end

  // Writes and strobes act in the ack cycle
  always_comb begin
    wr_ctl   = wreq_q && (woff_q == 6'h01);
    snap_stb = wr_ctl && wdata_q[1];
    clr_stb  = wr_ctl && wdata_q[2];
    w1c_err  = '0;
    w1c_oos  = '0;
    if (wreq_q && woff_q == 6'h02) w1c_err = wdata_q[NC-1:0];
    if (wreq_q && woff_q == 6'h03) w1c_oos = wdata_q[NC-1:0];
    count_en_d = wr_ctl ? wdata_q[0] : count_en_q;
    mask_d = mask_q;
    if (wreq_q && woff_q == 6'h04) mask_d = wdata_q[NC-1:0];
    err_d = (err_q & ~w1c_err) | act_err;
    oos_d = (oos_q & ~w1c_oos) | act_oos;
    irq_d = |((err_q | oos_q) & ~mask_q);
  end

  // Snapshot restarts the live count but keeps this cycle's error
  always_comb begin
    inc  = 1'b0;
    base = '0;
    for (int i = 0; i < NC; i++) begin
      inc  = count_en_q & act_err[i];
      base = snap_stb ? '0 : live_q[i];
      live_d[i] = (inc && base != '1) ? base + cnt_t'(1) : base;
      snap_d[i] = snap_stb ? live_q[i] : snap_q[i];
      if (clr_stb) begin
        live_d[i] = '0;
        snap_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wreq_q     <= 1'b0;
      woff_q     <= '0;
      wdata_q    <= '0;
      rack_q     <= 1'b0;
      rdata_q    <= '0;
      count_en_q <= 1'b0;
      err_q      <= '0;
      oos_q      <= '0;
      mask_q     <= '1;
      irq_q      <= 1'b0;
      for (int i = 0; i < NC; i++) begin
        live_q[i] <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      wreq_q     <= wreq_d;
      woff_q     <= woff_d;
      wdata_q    <= wdata_d;
      rack_q     <= rack_d;
      rdata_q    <= rdata_d;
      count_en_q <= count_en_d;
      err_q      <= err_d;
      oos_q      <= oos_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
      for (int i = 0; i < NC; i++) begin
        live_q[i] <= live_d[i];
        snap_q[i] <= snap_d[i];
      end
    end
  end

  assign up.up_wack  = wreq_q;
  assign up.up_rack  = rack_q;
  assign up.up_rdata = rdata_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_stats.sv
// Directed bench: two instances (16-bit and 8-bit counters)
// sharing the monitor inputs, read results via a scoreboard.
module tb_ad_ip_jesd204_tpl_adc_pn_stats;

  localparam logic [9:0] BASE = 10'h200;
  localparam logic [5:0] O_INFO = 6'h00;
  localparam logic [5:0] O_CTRL = 6'h01;
  localparam logic [5:0] O_SERR = 6'h02;
  localparam logic [5:0] O_SOOS = 6'h03;
  localparam logic [5:0] O_MASK = 6'h04;
  localparam logic [5:0] O_LOOS = 6'h05;
  localparam logic [5:0] O_SNAP = 6'h10;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] pn_err, pn_oos, enable;
  logic irq_a, irq_b;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_adc_pn_stats_if bus_a ();
  ad_ip_jesd204_tpl_adc_pn_stats_if bus_b ();

  ad_ip_jesd204_tpl_adc_pn_stats #(
    .NUM_CHANNELS(4), .COUNTER_WIDTH(16), .BASE_ADDR(BASE)
  ) dut_a (
    .clk(clk), .reset(reset), .up(bus_a),
    .pn_err(pn_err), .pn_oos(pn_oos),
    .enable(enable), .irq(irq_a)
  );

  ad_ip_jesd204_tpl_adc_pn_stats #(
    .NUM_CHANNELS(4), .COUNTER_WIDTH(8), .BASE_ADDR(BASE)
  ) dut_b (
    .clk(clk), .reset(reset), .up(bus_b),
    .pn_err(pn_err), .pn_oos(pn_oos),
    .enable(enable), .irq(irq_b)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input bit b, input logic [5:0] off,
                    input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    if (b) begin
      bus_b.up_rreq = 1'b1;
      bus_b.up_raddr = BASE | 10'(off);
    end else begin
      bus_a.up_rreq = 1'b1;
      bus_a.up_raddr = BASE | 10'(off);
    end
    @(negedge clk);
    bus_a.up_rreq = 1'b0;
    bus_b.up_rreq = 1'b0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    if (b) begin
      chk({t, "_ack"}, 32'(bus_b.up_rack), 32'd1);
      chk(t, bus_b.up_rdata, e);
    end else begin
      chk({t, "_ack"}, 32'(bus_a.up_rack), 32'd1);
      chk(t, bus_a.up_rdata, e);
    end
  endtask

  // pn_ack is what pn_err carries during the ack cycle
  task automatic wr(input bit b, input logic [5:0] off,
                    input logic [31:0] data,
                    input logic [3:0] pn_ack, input string tag);
    logic [3:0] save;
    save = pn_err;
    @(negedge clk);
    if (b) begin
      bus_b.up_wreq = 1'b1;
      bus_b.up_waddr = BASE | 10'(off);
      bus_b.up_wdata = data;
    end else begin
      bus_a.up_wreq = 1'b1;
      bus_a.up_waddr = BASE | 10'(off);
      bus_a.up_wdata = data;
    end
    @(posedge clk);
    #1;
    bus_a.up_wreq = 1'b0;
    bus_b.up_wreq = 1'b0;
    pn_err = pn_ack;
    @(negedge clk);
    if (b) chk({tag, "_wack"}, 32'(bus_b.up_wack), 32'd1);
    else   chk({tag, "_wack"}, 32'(bus_a.up_wack), 32'd1);
    @(posedge clk);
    #1;
    pn_err = save;
  endtask

  initial begin
    reset  = 1'b1;
    pn_err = '0;
    pn_oos = '0;
    enable = '1;
    bus_a.up_wreq = 1'b0; bus_a.up_waddr = '0;
    bus_a.up_wdata = '0;  bus_a.up_rreq = 1'b0;
    bus_a.up_raddr = '0;
    bus_b.up_wreq = 1'b0; bus_b.up_waddr = '0;
    bus_b.up_wdata = '0;  bus_b.up_rreq = 1'b0;
    bus_b.up_raddr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wack", 32'(bus_a.up_wack), 32'd0);
    chk("rst_rack", 32'(bus_a.up_rack), 32'd0);
    chk("rst_rdata", bus_a.up_rdata, 32'd0);
    chk("rst_irq", 32'(irq_a), 32'd0);

    rd(0, O_INFO, 32'h0110_0004, "info_a");
    rd(1, O_INFO, 32'h0108_0004, "info_b");
    rd(0, O_MASK, 32'h0000_000F, "mask_rst");
    rd(0, O_CTRL, 32'h0, "ctrl_rst");

    // Out-of-window read and write
    @(negedge clk);
    bus_a.up_rreq = 1'b1;
    bus_a.up_raddr = BASE + 10'h040;
    bus_a.up_wreq = 1'b1;
    bus_a.up_waddr = 10'h1C4;
    bus_a.up_wdata = 32'h0;
    @(negedge clk);
    bus_a.up_rreq = 1'b0;
    bus_a.up_wreq = 1'b0;
    chk("oow_rack", 32'(bus_a.up_rack), 32'd0);
    chk("oow_rdata", bus_a.up_rdata, 32'd0);
    chk("oow_wack", 32'(bus_a.up_wack), 32'd0);
    rd(0, O_MASK, 32'h0000_000F, "mask_oow");
    rd(0, O_SNAP + 6'd4, 32'h0, "snap_oor");
    rd(0, 6'h3F, 32'h0, "unmapped");

    // Ten errors on channel 2
    wr(0, O_CTRL, 32'h1, pn_err, "cen_a");
    wr(1, O_CTRL, 32'h1, pn_err, "cen_b");
    rd(0, O_CTRL, 32'h1, "ctrl_en");
    @(negedge clk);
    pn_err = 4'b0100;
    repeat (10) @(negedge clk);
    pn_err = 4'b0000;
    wr(0, O_CTRL, 32'h3, pn_err, "snap1");
    for (int i = 0; i < 4; i++)
      rd(0, O_SNAP + 6'(i), (i == 2) ? 32'd10 : 32'd0,
         $sformatf("snap10_%0d", i));

    // Error in the snapshot cycle lands in the new live count
    wr(0, O_CTRL, 32'h3, 4'b0100, "snap2");
    rd(0, O_SNAP + 6'd2, 32'd0, "snap_edge0");
    wr(0, O_CTRL, 32'h3, 4'b0000, "snap3");
    rd(0, O_SNAP + 6'd2, 32'd1, "snap_edge1");

    // Saturation on the 8-bit instance, channel 1 disabled
    wr(1, O_CTRL, 32'h5, pn_err, "clr_b");
    wr(0, O_SERR, 32'hF, pn_err, "w1c_pre");
    enable = 4'b1101;
    @(negedge clk);
    pn_err = 4'b0011;
    repeat (300) @(negedge clk);
    pn_err = 4'b0000;
    wr(1, O_CTRL, 32'h3, pn_err, "snap_b");
    rd(1, O_SNAP, 32'h0000_00FF, "sat_ch0");
    rd(1, O_SNAP + 6'd1, 32'h0, "dis_ch1");
    rd(0, O_SERR, 32'h1, "serr_dis");
    enable = 4'b1111;
    wr(0, O_SERR, 32'hF, pn_err, "w1c_all");
    rd(0, O_SERR, 32'h0, "serr_clr");

    // Out-of-sync: live and sticky
    @(negedge clk);
    pn_oos = 4'b0010;
    rd(0, O_LOOS, 32'h2, "live_oos");
    pn_oos = 4'b0000;
    rd(0, O_SOOS, 32'h2, "soos_set");
    rd(0, O_LOOS, 32'h0, "live_oos0");
    wr(0, O_SOOS, 32'h2, pn_err, "soos_w1c");
    rd(0, O_SOOS, 32'h0, "soos_clr");

    // Interrupt path
    @(negedge clk);
    pn_err = 4'b1000;
    @(negedge clk);
    pn_err = 4'b0000;
    rd(0, O_SERR, 32'h8, "serr_p3");
    chk("irq_masked", 32'(irq_a), 32'd0);
    wr(0, O_MASK, 32'h0, pn_err, "unmask");
    @(negedge clk);
    chk("irq_lat0", 32'(irq_a), 32'd0);
    @(negedge clk);
    chk("irq_on", 32'(irq_a), 32'd1);
    rd(0, O_MASK, 32'h0, "mask_0");
    wr(0, O_SERR, 32'h8, 4'b1000, "w1c_race");
    rd(0, O_SERR, 32'h8, "set_wins");
    chk("irq_hold", 32'(irq_a), 32'd1);
    wr(0, O_SERR, 32'h8, 4'b0000, "w1c_ok");
    @(negedge clk);
    chk("irq_lat1", 32'(irq_a), 32'd1);
    @(negedge clk);
    chk("irq_off", 32'(irq_a), 32'd0);
    rd(0, O_SERR, 32'h0, "serr_0");

    // Snapshot plus clear: clear wins, count_en stays
    @(negedge clk);
    pn_err = 4'b0010;
    repeat (5) @(negedge clk);
    pn_err = 4'b0000;
    wr(0, O_CTRL, 32'h7, pn_err, "ctrl7");
    for (int i = 0; i < 4; i++)
      rd(0, O_SNAP + 6'(i), 32'd0, $sformatf("clr_%0d", i));
    rd(0, O_CTRL, 32'h1, "ctrl_rb");
    rd(0, O_SERR, 32'h2, "serr_keep");
    @(negedge clk);
    pn_err = 4'b0010;
    repeat (3) @(negedge clk);
    pn_err = 4'b0000;
    wr(0, O_CTRL, 32'h3, pn_err, "snap4");
    rd(0, O_SNAP + 6'd1, 32'd3, "post_clr1");
    rd(0, O_SNAP, 32'd0, "post_clr0");

    // Reset while a read is pending
    @(negedge clk);
    bus_a.up_rreq = 1'b1;
    bus_a.up_raddr = BASE | 10'(O_INFO);
    reset = 1'b1;
    @(negedge clk);
    bus_a.up_rreq = 1'b0;
    chk("rst_drop", 32'(bus_a.up_rack), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_drop2", 32'(bus_a.up_rack), 32'd0);
    chk("rst_irq2", 32'(irq_a), 32'd0);
    rd(0, O_MASK, 32'hF, "mask_rst2");
    rd(0, O_CTRL, 32'h0, "ctrl_rst2");
    rd(0, O_SERR, 32'h0, "serr_rst2");
    wr(0, O_CTRL, 32'h2, pn_err, "snap5");
    rd(0, O_SNAP + 6'd1, 32'h0, "cnt_rst2");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
